// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, control-word bit positions, ALUOp codes,
// immediate formats and the immediate extraction helper.
package decode_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int CTRL_ALUSRC    = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_REGWRITE  = 5;
  localparam int CTRL_MEMREAD   = 4;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IALU   = 2'b11;

  localparam logic [7:0] CTRL_RTYPE  = (8'd1 << CTRL_REGWRITE) | (8'(ALUOP_RTYPE) << CTRL_ALUOP_LSB);
  localparam logic [7:0] CTRL_IALU   = (8'd1 << CTRL_ALUSRC) | (8'd1 << CTRL_REGWRITE)
                                     | (8'(ALUOP_IALU) << CTRL_ALUOP_LSB);
  localparam logic [7:0] CTRL_LOAD   = (8'd1 << CTRL_ALUSRC) | (8'd1 << CTRL_MEMTOREG)
                                     | (8'd1 << CTRL_REGWRITE) | (8'd1 << CTRL_MEMREAD)
                                     | (8'(ALUOP_ADD) << CTRL_ALUOP_LSB);
  localparam logic [7:0] CTRL_STORE  = (8'd1 << CTRL_ALUSRC) | (8'd1 << CTRL_MEMWRITE)
                                     | (8'(ALUOP_ADD) << CTRL_ALUOP_LSB);
  localparam logic [7:0] CTRL_BRANCH_W = (8'd1 << CTRL_BRANCH) | (8'(ALUOP_BRANCH) << CTRL_ALUOP_LSB);
  localparam logic [7:0] CTRL_JAL    = (8'd1 << CTRL_REGWRITE) | (8'd1 << CTRL_BRANCH)
                                     | (8'(ALUOP_ADD) << CTRL_ALUOP_LSB);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   imm_gen = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm_gen = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Two-read/one-write register file with x0 hard-wired to zero.
// With DECODE_BYPASS_EN defined, a same-cycle write is visible on the read ports.
module regfile #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  localparam int RW       = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RW-1:0]   raddr1_i,
  input  logic [RW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef DECODE_BYPASS_EN
  assign rdata1_o = (raddr1_i == '0) ? '0 : ((wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i]);
  assign rdata2_o = (raddr2_i == '0) ? '0 : ((wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i]);
`else
  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`endif

endmodule

// File: rtl/decode_stage.sv
// RISC-V ID stage: decode, register read, immediate generation, load-use
// hazard detection and the ID/EX register. Optional macro: DECODE_BYPASS_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [3:0]      id_ex_alu_ctrl,
  output logic [7:0]      id_ex_ctrl,
  output logic [31:0]     stall_count
);

  localparam int RW = $clog2(REG_COUNT);

  logic [4:0]      rs1, rs2, rd;
  logic [7:0]      ctrl;
  imm_fmt_e        imm_fmt;
  logic            legal, uses_rs2;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q, d1_d, d1_q, d2_d, d2_q, imm_d, imm_q;
  logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [3:0]      alu_d, alu_q;
  logic [7:0]      ctrl_d, ctrl_q;
  logic [31:0]     cnt_d, cnt_q;

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd  = if_instr[11:7];

  regfile #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we),
    .waddr_i  (wb_addr[RW-1:0]),
    .wdata_i  (wb_data),
    .raddr1_i (rs1[RW-1:0]),
    .raddr2_i (rs2[RW-1:0]),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // Opcode decode: control word, immediate format and rs2 usage
  always_comb begin
    ctrl     = 8'h00;
    imm_fmt  = IMM_NONE;
    legal    = 1'b1;
    uses_rs2 = 1'b0;
    case (if_instr[6:0])
      OPC_RTYPE:  begin ctrl = CTRL_RTYPE;    uses_rs2 = 1'b1; end
      OPC_IALU:   begin ctrl = CTRL_IALU;     imm_fmt = IMM_I; end
      OPC_LOAD:   begin ctrl = CTRL_LOAD;     imm_fmt = IMM_I; end
      OPC_STORE:  begin ctrl = CTRL_STORE;    imm_fmt = IMM_S; uses_rs2 = 1'b1; end
      OPC_BRANCH: begin ctrl = CTRL_BRANCH_W; imm_fmt = IMM_B; uses_rs2 = 1'b1; end
      OPC_JAL:    begin ctrl = CTRL_JAL;      imm_fmt = IMM_J; end
      default:    legal = 1'b0;
    endcase
  end

  assign imm = XLEN'($signed(imm_gen(if_instr, imm_fmt)));

  assign stall = ex_mem_read && (ex_rd != 5'd0) && if_valid
              && ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));

  // Anything other than a live, legal, unstalled instruction becomes an all-zero
  // bubble so downstream never sees stray control bits.
  always_comb begin
    valid_d = 1'b0;
    pc_d    = '0;
    d1_d    = '0;
    d2_d    = '0;
    imm_d   = '0;
    rs1_d   = 5'd0;
    rs2_d   = 5'd0;
    rd_d    = 5'd0;
    alu_d   = 4'd0;
    ctrl_d  = 8'd0;
    if (!flush && !stall && if_valid && legal) begin
      valid_d = 1'b1;
      pc_d    = if_pc;
      d1_d    = rs1_data;
      d2_d    = rs2_data;
      imm_d   = imm;
      rs1_d   = rs1;
      rs2_d   = rs2;
      rd_d    = rd;
      alu_d   = {if_instr[30], if_instr[14:12]};
      ctrl_d  = ctrl;
    end else begin
      valid_d = 1'b0;
    end
    if (stall && !flush && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // ID/EX boundary register and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      alu_q   <= 4'd0;
      ctrl_q  <= 8'd0;
      cnt_q   <= 32'd0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_ex_valid    = valid_q;
  assign id_ex_pc       = pc_q;
  assign id_ex_rs1_data = d1_q;
  assign id_ex_rs2_data = d2_q;
  assign id_ex_imm      = imm_q;
  assign id_ex_rs1      = rs1_q;
  assign id_ex_rs2      = rs2_q;
  assign id_ex_rd       = rd_q;
  assign id_ex_alu_ctrl = alu_q;
  assign id_ex_ctrl     = ctrl_q;
  assign stall_count    = cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RISC-V instruction-decode stage with a registered ID/EX pipeline boundary. It decodes the incoming instruction, reads a multi-port register file and sign-extends the immediate. It detects load-use hazards, stalls the fetch stage and inserts bubbles, and flushes on a taken branch. It sits between the fetch stage and the execute stage and accepts write-back traffic from the final stage.

## Interface
- XLEN, 32, datapath and register width; immediate is sign-extended to XLEN.
- REG_COUNT, 32, architectural registers; power of two, at most 32; register index width RW = $clog2(REG_COUNT).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- if_valid  in  1  fetch presents a valid instruction.
- if_pc  in  XLEN  PC of the presented instruction.
- if_instr  in  32  instruction word.
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back register index.
- wb_data  in  XLEN  write-back data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- flush  in  1  taken branch or jump; kill the instruction in ID.
- stall  out  1  combinational; fetch must hold PC and instruction.
- id_ex_valid  out  1  ID/EX register holds a real instruction.
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  XLEN each  registered.
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered register indices.
- id_ex_alu_ctrl  out  4  {instr[30], instr[14:12]}.
- id_ex_ctrl  out  8  {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}.
- stall_count  out  32  saturating count of stall cycles.

## Operation
- Opcodes decoded:
  - R-type 0110011: ctrl 8'b00100010.
  - I-ALU 0010011: ctrl 8'b10100011.
  - Load 0000011: ctrl 8'b11110000.
  - Store 0100011: ctrl 8'b10001000.
  - Branch 1100011: ctrl 8'b00000101.
  - JAL 1101111: ctrl 8'b00100100.
  - Any other opcode: ctrl 0, and id_ex_valid is 0.
- Immediate formats:
  - I: loads and I-ALU.
  - S: stores.
  - B: branches; bit 0 is 0.
  - J: JAL; bit 0 is 0.
  - R-type: immediate is 0.
  - All formats sign-extend from instr[31].
- Register file:
  - REG_COUNT×XLEN, written on the rising edge when wb_we is high and wb_addr is nonzero.
  - Register 0 always reads 0.
  - Index bits at or above RW are ignored.
- Hazard: stall = ex_mem_read && ex_rd≠0 && if_valid && (ex_rd==rs1 || (instruction uses rs2 && ex_rd==rs2)).
  - rs2 is used by R-type, store and branch.
- Pipeline register update, in priority order:
  - rst: clear to bubble.
  - flush: load bubble.
  - stall: load bubble; the instruction stays in ID.
  - Otherwise: load the decoded if_* fields, with id_ex_valid = if_valid.
- Bubble: id_ex_valid=0 and id_ex_ctrl=0; all other fields 0.
- stall_count increments on every cycle where stall is high and flush is low; it saturates at all-ones.

## Timing
- Latency: an instruction presented in cycle N appears on id_ex_* in cycle N+1.
- stall and the decode logic are combinational from if_instr, ex_mem_read and ex_rd in the same cycle.
- A load-use pair always costs exactly one bubble cycle. In the next cycle the load has left EX, so stall deasserts.
- flush and stall asserted in the same cycle: flush wins; the bubble is loaded and stall_count does not increment.
- Write-back and read of the same register in the same cycle: behaviour is set by DECODE_BYPASS_EN.
- Reset mid-operation: all outputs are 0 immediately, including stall_count and every register.
- After reset, stall is 0 until inputs cause a hazard.

## Configuration
- DECODE_BYPASS_EN, defined: write-through bypass. A read whose index matches a nonzero wb_addr with wb_we high returns wb_data in the same cycle.
- DECODE_BYPASS_EN, undefined: the read returns the pre-write value. In that case the pipeline must cover the WB→ID distance with forwarding or an extra stall.

## Structure
- Package decode_pkg holds:
  - Opcode constants.
  - Control-bit position localparams.
  - ALUOp encodings 00, 01, 10, 11.
  - Immediate-format enum typedef.
- Sub-module regfile, parametrised by XLEN and REG_COUNT.
  - Two read ports, one write port.
  - Asynchronous reset.
  - Bypass under DECODE_BYPASS_EN.
- Decode, hazard logic, immediate generation and the ID/EX register live in decode_stage.

## Test plan
- Reset then `add x3,x1,x2` (0x002081B3) with x1=5, x2=7 preloaded -> next cycle: id_ex_rs1_data=5, id_ex_rs2_data=7, id_ex_rd=3, id_ex_ctrl=0x22, id_ex_valid=1.
- `lw x5,-4(x2)` (0xFFC12283) -> id_ex_imm=0xFFFFFFFC, ctrl=0xF0.
- `sw x6,8(x2)` (0x00612423) -> id_ex_imm=8, ctrl=0x88.
- ex_mem_read=1, ex_rd=5, instruction `add x7,x5,x1` -> stall=1 for one cycle and a bubble; the next cycle shows the add with valid=1; stall_count=1.
- flush=1 together with a hazard stall -> bubble loaded; stall_count unchanged.
- wb_we=1, wb_addr=1, wb_data=0xDEAD in the same cycle the add reads x1 -> with DECODE_BYPASS_EN, id_ex_rs1_data=0xDEAD; without it, the old value.
- Write to x0 -> later reads of x0 return 0.
